// File: rtl/out_stage.sv
// Output stage: mixes the filtered and bypass waves, applies master volume through
// the shared multiplier, and drives a first-order delta-sigma bitstream.
module out_stage (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic signed [13:0]  filt_wave_i,
    input  logic signed [13:0]  bypass_wave_i,
    input  logic [3:0]          volume_i,
    input  logic                mult_ready_i,
    input  logic signed [39:0]  mult_prod_i,
    output logic signed [23:0]  mult_a_o,
    output logic signed [15:0]  mult_b_o,
    output logic                mult_start_o,
    output logic                ready_o,
    output logic signed [15:0]  sample_o,
    output logic                pdm_o
);

    // state | meaning
    // IDLE  | wait for start_i, latch inputs on accept
    // SUM   | add latched filter and bypass waves into mix
    // MULT  | present operands, pulse multiplier start
    // WAIT  | hold until the multiplier result is valid
    // SCALE | take product, double and saturate into sample_o
    // DONE  | sample_o visible, ready_o pulse
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SUM   = 3'd1,
        MULT  = 3'd2,
        WAIT  = 3'd3,
        SCALE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_q;
    logic signed [13:0]  filt_q;
    logic signed [13:0]  bypass_q;
    logic [3:0]          vol_q;
    logic signed [23:0]  mix_q;
    logic [16:0]         acc_q;

    logic signed [23:0]  scaled;
    logic signed [24:0]  doubled;
    logic signed [15:0]  sat_sample;
    logic [15:0]         pdm_u;
    logic                prod_unused;

    // Product is Q1.15-scaled; bit 39 and the fraction bits are never needed.
    assign scaled      = mult_prod_i[38:15];
    assign doubled     = {scaled, 1'b0};
    assign prod_unused = ^{mult_prod_i[39], mult_prod_i[14:0]};

    always_comb begin
        sat_sample = doubled[15:0];
        if (doubled[24:15] != {10{doubled[24]}}) begin
            sat_sample = doubled[24] ? 16'sh8000 : 16'sh7fff;
        end
    end

    assign mult_start_o = (state_q == MULT);
    assign mult_a_o     = mult_start_o ? mix_q : 24'sd0;
    assign mult_b_o     = mult_start_o ? {1'b0, vol_q, 11'b0} : 16'sd0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            filt_q   <= '0;
            bypass_q <= '0;
            vol_q    <= '0;
            mix_q    <= '0;
            sample_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        filt_q   <= filt_wave_i;
                        bypass_q <= bypass_wave_i;
                        vol_q    <= volume_i;
                        state_q  <= SUM;
                    end
                end
                SUM: begin
                    mix_q   <= {{10{filt_q[13]}}, filt_q} + {{10{bypass_q[13]}}, bypass_q};
                    state_q <= MULT;
                end
                MULT: state_q <= WAIT;
                WAIT: begin
                    if (mult_ready_i) begin
                        state_q <= SCALE;
                    end
                end
                SCALE: begin
                    sample_o <= sat_sample;
                    ready_o  <= 1'b1;
                    state_q  <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Offset-binary input to the modulator; the carry out of bit 15 is the bitstream.
    assign pdm_u = {~sample_o[15], sample_o[14:0]};
    assign pdm_o = acc_q[16];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= {1'b0, acc_q[15:0]} + {1'b0, pdm_u};
        end
    end

endmodule
